// File: rtl/wb_sram_port0_ctrl_if.sv
// Wishbone classic slave bus as seen by the SRAM port-0 controller.
// A transfer is requested while cyc & stb are high. It completes with a single-cycle ack.
// The master keeps cyc high until it sees that ack; dropping cyc earlier abandons the ack.
interface wb_sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  wbs_cyc_i;
  logic                  wbs_stb_i;
  logic                  wbs_we_i;
  logic [NUM_WMASKS-1:0] wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [DATA_WIDTH-1:0] wbs_dat_i;
  logic                  wbs_ack_o;
  logic [DATA_WIDTH-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_port0_ctrl.sv
// Converts single Wishbone classic transfers into one-cycle strobed accesses on
// port 0 of a byte-maskable SRAM macro clocked from the same wb_clk_i.
module wb_sram_port0_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 9,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_sram_port0_ctrl_if.slave   wbs,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   we_q;
  logic   hit;

  assign hit = wbs.wbs_cyc_i && wbs.wbs_stb_i &&
               (wbs.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  assign dbg_state = state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
      sram_csb0     <= 1'b1;
      sram_web0     <= 1'b1;
      sram_wmask0   <= '0;
      sram_addr0    <= '0;
      sram_din0     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~wbs.wbs_we_i;
            sram_addr0  <= wbs.wbs_adr_i[ADDR_WIDTH+1:2];
            sram_din0   <= wbs.wbs_dat_i;
            sram_wmask0 <= wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
            we_q        <= wbs.wbs_we_i;
            state       <= ISSUE;
          end
        end
        // The macro samples its inputs at this edge; the access completes even
        // if the master has dropped cyc, only the ack is withheld.
        ISSUE: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          if (we_q) begin
            wbs.wbs_ack_o <= wbs.wbs_cyc_i;
            state         <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          wbs.wbs_dat_o <= sram_dout0;
          wbs.wbs_ack_o <= wbs.wbs_cyc_i;
          state         <= RESP;
        end
        // stb is deliberately ignored here so a held strobe cannot re-trigger.
        RESP: begin
          wbs.wbs_ack_o <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_port0_ctrl.sv
// Bench for wb_sram_port0_ctrl: behavioural SRAM macro, directed scenarios and
// randomized transfers checked against a word-array reference of memory contents.
module tb_wb_sram_port0_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic [1:0]  dbg_state;

  wb_sram_port0_ctrl_if #(.DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

  wb_sram_port0_ctrl #(
    .BASE_ADDR (BASE),
    .ADDR_WIDTH(9),
    .DATA_WIDTH(32),
    .NUM_WMASKS(4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs        (bus.slave),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM macro: capture at posedge, write lands / dout updates at negedge
  logic [31:0] sram_mem [512];
  logic        cap_v, cap_we;
  logic [8:0]  cap_a;
  logic [31:0] cap_d;
  logic [3:0]  cap_m;

  initial begin
    for (int i = 0; i < 512; i++) sram_mem[i] = 32'h0;
    sram_dout0 = 32'h0;
    cap_v = 1'b0;
  end

  always @(posedge clk) begin
    cap_v  <= !sram_csb0;
    cap_we <= !sram_web0;
    cap_a  <= sram_addr0;
    cap_d  <= sram_din0;
    cap_m  <= sram_wmask0;
  end

  always @(negedge clk) begin
    if (cap_v) begin
      if (cap_we) begin
        for (int b = 0; b < 4; b++)
          if (cap_m[b]) sram_mem[cap_a][8*b +: 8] <= cap_d[8*b +: 8];
      end else begin
        sram_dout0 <= sram_mem[cap_a];
      end
    end
  end

  // bus monitor
  int          csb_cnt = 0;
  int          ack_cnt = 0;
  int          csb_double = 0;
  logic        prev_csb = 1'b1;
  logic [8:0]  mon_addr;
  logic [3:0]  mon_wmask;
  logic [31:0] mon_din;
  logic        mon_web;

  always @(negedge clk) begin
    if (!sram_csb0) begin
      csb_cnt   <= csb_cnt + 1;
      mon_addr  <= sram_addr0;
      mon_wmask <= sram_wmask0;
      mon_din   <= sram_din0;
      mon_web   <= sram_web0;
      if (!prev_csb) csb_double <= csb_double + 1;
    end
    if (bus.wbs_ack_o) ack_cnt <= ack_cnt + 1;
    prev_csb <= sram_csb0;
  end

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [512];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one complete master transfer plus all checks derived from the reference
  task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit scramble);
    int          lat;
    int          c0, a0;
    bit          hit;
    logic [8:0]  w;
    logic [31:0] exp_rd;
    hit = (adr[31:11] == BASE[31:11]);
    w   = adr[10:2];
    c0  = csb_cnt;
    a0  = ack_cnt;
    lat = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (scramble) begin
        bus.wbs_dat_i = $urandom;
        bus.wbs_sel_i = 4'($urandom_range(0, 15));
        bus.wbs_adr_i = adr ^ (32'($urandom_range(1, 511)) << 2);
      end
      if (bus.wbs_ack_o) begin
        lat = n;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    if (hit) begin
      check("ack_latency", 32'(lat), we ? 32'd2 : 32'd3);
      check("csb_pulses", 32'(csb_cnt - c0), 32'd1);
      check("addr0", {23'h0, mon_addr}, {23'h0, w});
      check("wmask0", {28'h0, mon_wmask}, we ? {28'h0, sel} : 32'h0);
      check("web0", {31'h0, mon_web}, {31'h0, !we});
      if (we) begin
        check("din0", mon_din, dat);
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
        exp_rd = last_rd;
      end else begin
        exp_rd = ref_mem[w];
      end
      last_rd = exp_rd;
      check("dat_o", bus.wbs_dat_o, exp_rd);
      tick();
      check("ack_width", {31'h0, bus.wbs_ack_o}, 32'h0);
    end else begin
      check("miss_ack", 32'(ack_cnt - a0), 32'd0);
      check("miss_csb", 32'(csb_cnt - c0), 32'd0);
    end
    tick();
  endtask

  initial begin
    int c0, a0;
    logic [8:0] w;
    logic [31:0] adr;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    last_rd = 32'h0;
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_sel_i = 4'h0;
    repeat (3) tick();
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_csb", {31'h0, sram_csb0}, 32'h1);
      check("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check("rst_dat", bus.wbs_dat_o, 32'h0);
    end

    // directed write / read / partial write
    run_xfer(1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF, 1'b0);
    run_xfer(1'b0, 32'h3000_0008, 32'h0, 4'h0, 1'b0);
    check("rd_deadbeef", bus.wbs_dat_o, 32'hDEAD_BEEF);
    run_xfer(1'b1, 32'h3000_0008, 32'h1122_3344, 4'b0101, 1'b0);
    run_xfer(1'b0, 32'h3000_0008, 32'h0, 4'h0, 1'b0);
    check("rd_partial", bus.wbs_dat_o, 32'hDE22_BE44);

    // sel=0 write leaves memory untouched
    run_xfer(1'b1, 32'h3000_0008, 32'hFFFF_FFFF, 4'h0, 1'b0);
    run_xfer(1'b0, 32'h3000_000B, 32'h0, 4'h0, 1'b0);
    check("rd_sel0", bus.wbs_dat_o, 32'hDE22_BE44);

    // miss
    run_xfer(1'b0, 32'h3100_0000, 32'h0, 4'h0, 1'b0);

    // abort: drop cyc in ISSUE on a write to the top word
    c0 = csb_cnt;
    a0 = ack_cnt;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = 32'h3000_07FC;
    bus.wbs_dat_i = 32'hA5A5_A5A5;
    bus.wbs_sel_i = 4'hF;
    tick();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    repeat (4) tick();
    check("abort_ack", 32'(ack_cnt - a0), 32'd0);
    check("abort_csb", 32'(csb_cnt - c0), 32'd1);
    ref_mem[9'h1FF] = 32'hA5A5_A5A5;
    run_xfer(1'b0, 32'h3000_07FC, 32'h0, 4'h0, 1'b0);
    check("abort_rd", bus.wbs_dat_o, 32'hA5A5_A5A5);

    // reset while a read sits in CAPTURE
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h3000_0008;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("midrst_dat", bus.wbs_dat_o, 32'h0);
    check("midrst_csb", {31'h0, sram_csb0}, 32'h1);
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    last_rd = 32'h0;
    tick();
    run_xfer(1'b0, 32'h3000_0008, 32'h0, 4'h0, 1'b0);
    check("post_rst_rd", bus.wbs_dat_o, 32'hDE22_BE44);

    // randomized transfers, clustered on a few words so reads hit earlier writes
    for (int t = 0; t < 80; t++) begin
      w = ($urandom_range(0, 3) == 0) ? 9'(9'h1FF - $urandom_range(0, 3))
                                      : 9'($urandom_range(0, 7));
      adr = BASE | {21'h0, w, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) adr = adr ^ (32'h1 << $urandom_range(11, 31));
      run_xfer(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
    end

    check("csb_single_cycle", 32'(csb_double), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_sram_port0_ctrl.md
Name: wb_sram_port0_ctrl

Overview:
- Wishbone classic slave that converts single bus transfers into strobed accesses on port 0 (RW) of the 32x512 byte-maskable SRAM macro.
- Sits directly upstream of the SRAM macro: it drives csb0/web0/wmask0/addr0/din0, captures dout0, and returns data and ack to the user-project Wishbone bus.
- The SRAM clk0 is driven from wb_clk_i, so the macro captures at the same posedge the controller uses and updates dout0 on the following negedge.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte-address base of the SRAM window; bits below ADDR_WIDTH+2 are ignored.
- ADDR_WIDTH, 9, SRAM word-address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane count; equals DATA_WIDTH/8.

Ports:
- wb_clk_i  in  1  single clock for the block and the SRAM clk0; all logic on posedge.
- wb_rst_i  in  1  synchronous reset, active high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  transfer strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  NUM_WMASKS  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  DATA_WIDTH  write data.
- wbs_ack_o  out  1  transfer acknowledge, one cycle wide.
- wbs_dat_o  out  DATA_WIDTH  read data, held until the next read completes.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_wmask0  out  NUM_WMASKS  SRAM byte write mask.
- sram_addr0  out  ADDR_WIDTH  SRAM word address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data; valid from the negedge after capture.

Behaviour:
- Single clock wb_clk_i; reset is synchronous and active high. All outputs are registered.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0; state IDLE.
- Hit: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
- A transfer that does not hit is ignored: no SRAM access and no ack.
- Word address is wbs_adr_i[ADDR_WIDTH+1:2]; wbs_adr_i[1:0] is ignored.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, at posedge P0 with a hit:
  - sram_csb0<=0, sram_web0<=~wbs_we_i, sram_addr0<=word address.
  - sram_din0<=wbs_dat_i.
  - sram_wmask0<=wbs_sel_i for a write, 0 for a read.
  - Latch wbs_we_i; go to ISSUE.
- ISSUE, at posedge P1 (the SRAM captures its inputs at this edge):
  - sram_csb0<=1, sram_web0<=1.
  - Write: wbs_ack_o<=wbs_cyc_i; go to RESP.
  - Read: go to CAPTURE.
- CAPTURE, at posedge P2: wbs_dat_o<=sram_dout0 (updated at negedge P1); wbs_ack_o<=wbs_cyc_i; go to RESP.
- RESP: wbs_ack_o<=0; go to IDLE. Strobe is not sampled in this state, so a master still holding stb during the ack cycle does not trigger a second access.
- Latency from the posedge sampling the request to ack high: write 2 cycles, read 3 cycles.
- Back-to-back throughput: write 3 cycles/transfer, read 4 cycles/transfer.
- sram_csb0 is low for exactly one cycle per transfer.
- Bus inputs are sampled only in IDLE. A change of wbs_dat_i, wbs_sel_i or wbs_adr_i after P0 does not affect the access in flight.
- Abort: if wbs_cyc_i drops during ISSUE or CAPTURE, the SRAM access still completes (the write lands) but ack is suppressed.
- Aborted read: wbs_dat_o is still updated.
- Write with wbs_sel_i=0: the access is issued with wmask 0, memory is unchanged, and ack is returned.
- Read after write to the same word: the write lands at negedge P1, which is before the read's capture edge, so the read returns the new data.
- Address wrap: the top word (0x1FF) and word 0 are ordinary addresses; there is no special handling.
- Reset mid-operation: at the reset edge all outputs and state return to reset values and any pending ack is lost. An access already captured by the SRAM at that same edge may still complete inside the macro.
- Port 1 of the SRAM is not driven by this block.

Test Plan:
- Reset, then idle 5 cycles -> sram_csb0=1, ack=0, wbs_dat_o=0 throughout.
- Write adr=0x3000_0008, dat=0xDEADBEEF, sel=4'hF -> sram_csb0 low for exactly 1 cycle with addr0=2 and wmask0=4'hF; ack high 2 cycles after the request is sampled, for 1 cycle.
- Read back adr=0x3000_0008 -> ack 3 cycles after the request is sampled, wbs_dat_o=0xDEADBEEF.
- Write sel=4'b0101, dat=0x11223344 over 0xDEADBEEF, then read -> wbs_dat_o=0xDE22BE44.
- Read adr=0x3100_0000 (miss) -> no sram_csb0 pulse and no ack for 10 cycles.
- Drop cyc in ISSUE on a write of 0xA5A5A5A5 to word 0x1FF -> no ack; a subsequent read of 0x3000_07FC returns 0xA5A5A5A5.
- Assert wb_rst_i in CAPTURE -> next cycle ack=0, wbs_dat_o=0, sram_csb0=1; the next transfer completes normally.
